rect_fill_engine: RTL and testbench

Drawing engine directly upstream of the VGA frame buffer. Accepts one rectangle-fill command at a time over a valid/ready handshake. Clips the rectangle to the visible HD x VD area. Emits one frame-buffer write per pixel in raster order (row-major, x fastest) on the buffer's write port (we, x, y, 2-bit colour), honouring a write-ready stall from the buffer side.

---
 rtl/rect_fill_engine.sv | 145 ++++++++++++++
 tb/tb_rect_fill_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// Rectangle-fill drawing engine: clips one command to the visible area and
// streams one frame-buffer write per pixel in raster order, honouring write stalls.
module rect_fill_engine #(
  parameter int HSYNC_BITS = 11,
  parameter int VSYNC_BITS = 11,
  parameter int HD         = 1280,
  parameter int VD         = 1024
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [HSYNC_BITS-1:0] cmd_x0_i,
  input  logic [VSYNC_BITS-1:0] cmd_y0_i,
  input  logic [HSYNC_BITS-1:0] cmd_x1_i,
  input  logic [VSYNC_BITS-1:0] cmd_y1_i,
  input  logic [1:0]            cmd_color_i,
  input  logic                  wr_ready_i,
  output logic                  we_o,
  output logic [HSYNC_BITS-1:0] addr_x_o,
  output logic [VSYNC_BITS-1:0] addr_y_o,
  output logic [1:0]            color_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  empty_o
);

  localparam logic [HSYNC_BITS-1:0] X_LIMIT = HSYNC_BITS'(HD - 1);
  localparam logic [VSYNC_BITS-1:0] Y_LIMIT = VSYNC_BITS'(VD - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t state, state_n;

  logic [HSYNC_BITS-1:0] x0_q, x0_n;
  logic [HSYNC_BITS-1:0] cx1_q, cx1_n;
  logic [VSYNC_BITS-1:0] cy1_q, cy1_n;
  logic [HSYNC_BITS-1:0] addr_x_n;
  logic [VSYNC_BITS-1:0] addr_y_n;
  logic [1:0]            color_n;
  logic                  we_n, done_n, empty_n, ready_n, busy_n;

  logic                  accept;
  logic [HSYNC_BITS-1:0] clip_x1;
  logic [VSYNC_BITS-1:0] clip_y1;
  logic                  clip_empty;

  assign accept = cmd_valid_i & cmd_ready_o;

  // Clipping only shrinks the far corner; a start beyond the limit falls out
  // naturally as an empty rectangle because x0 > clipped x1.
  assign clip_x1    = (cmd_x1_i > X_LIMIT) ? X_LIMIT : cmd_x1_i;
  assign clip_y1    = (cmd_y1_i > Y_LIMIT) ? Y_LIMIT : cmd_y1_i;
  assign clip_empty = (cmd_x0_i > clip_x1) || (cmd_y0_i > clip_y1);

  always_comb begin
    state_n  = state;
    x0_n     = x0_q;
    cx1_n    = cx1_q;
    cy1_n    = cy1_q;
    addr_x_n = addr_x_o;
    addr_y_n = addr_y_o;
    color_n  = color_o;
    we_n     = we_o;
    done_n   = 1'b0;
    empty_n  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          x0_n  = cmd_x0_i;
          cx1_n = clip_x1;
          cy1_n = clip_y1;
          if (clip_empty) begin
            state_n = DONE;
            done_n  = 1'b1;
            empty_n = 1'b1;
          end else begin
            state_n  = FILL;
            we_n     = 1'b1;
            addr_x_n = cmd_x0_i;
            addr_y_n = cmd_y0_i;
            color_n  = cmd_color_i;
          end
        end
      end
      FILL: begin
        // Compare before incrementing so the counters never step past the clip limit.
        if (wr_ready_i) begin
          if (addr_x_o < cx1_q) begin
            addr_x_n = addr_x_o + HSYNC_BITS'(1);
          end else if (addr_y_o < cy1_q) begin
            addr_x_n = x0_q;
            addr_y_n = addr_y_o + VSYNC_BITS'(1);
          end else begin
            we_n    = 1'b0;
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        we_n    = 1'b0;
      end
    endcase

    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state       <= IDLE;
      x0_q        <= '0;
      cx1_q       <= '0;
      cy1_q       <= '0;
      addr_x_o    <= '0;
      addr_y_o    <= '0;
      color_o     <= '0;
      we_o        <= 1'b0;
      done_o      <= 1'b0;
      empty_o     <= 1'b0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_n;
      x0_q        <= x0_n;
      cx1_q       <= cx1_n;
      cy1_q       <= cy1_n;
      addr_x_o    <= addr_x_n;
      addr_y_o    <= addr_y_n;
      color_o     <= color_n;
      we_o        <= we_n;
      done_o      <= done_n;
      empty_o     <= empty_n;
      cmd_ready_o <= ready_n;
      busy_o      <= busy_n;
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed cases plus randomized
// rectangles compared against a pixel-list reference model.
module tb_rect_fill_engine;

  localparam int HD = 1280;
  localparam int VD = 1024;

  logic        clk;
  logic        arstn;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [10:0] cmd_x0_i, cmd_x1_i;
  logic [10:0] cmd_y0_i, cmd_y1_i;
  logic [1:0]  cmd_color_i;
  logic        wr_ready_i;
  logic        we_o;
  logic [10:0] addr_x_o;
  logic [10:0] addr_y_o;
  logic [1:0]  color_o;
  logic        busy_o, done_o, empty_o;

  int checks = 0;
  int errors = 0;

  rect_fill_engine #(
    .HSYNC_BITS(11), .VSYNC_BITS(11), .HD(HD), .VD(VD)
  ) dut (
    .clk(clk), .arstn(arstn),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x0_i(cmd_x0_i), .cmd_y0_i(cmd_y0_i),
    .cmd_x1_i(cmd_x1_i), .cmd_y1_i(cmd_y1_i),
    .cmd_color_i(cmd_color_i), .wr_ready_i(wr_ready_i),
    .we_o(we_o), .addr_x_o(addr_x_o), .addr_y_o(addr_y_o),
    .color_o(color_o), .busy_o(busy_o), .done_o(done_o), .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // mode: 0 wr_ready always high, 1 random stalls, 2 stall on cycles 2-4,
  // 3 keep cmd_valid_i high with scrambled fields during the fill.
  task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                               input int color, input int mode);
    int  q_x[$];
    int  q_y[$];
    int  cx1, cy1, total, wait_cnt, cyc, budget;
    bit  r, finished;
    cx1 = (x1 > HD - 1) ? HD - 1 : x1;
    cy1 = (y1 > VD - 1) ? VD - 1 : y1;
    for (int y = y0; y <= cy1; y++)
      for (int x = x0; x <= cx1; x++) begin
        q_x.push_back(x);
        q_y.push_back(y);
      end
    total  = q_x.size();
    budget = 4 * total + 20;

    wait_cnt = 0;
    while (!cmd_ready_o && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    checkOutput("ready_before_cmd", cmd_ready_o, 1);

    cmd_x0_i    = 11'(x0);
    cmd_y0_i    = 11'(y0);
    cmd_x1_i    = 11'(x1);
    cmd_y1_i    = 11'(y1);
    cmd_color_i = 2'(color);
    cmd_valid_i = 1'b1;
    wr_ready_i  = 1'b1;
    @(posedge clk); #1;
    if (mode != 3) cmd_valid_i = 1'b0;
    checkOutput("ready_after_accept", cmd_ready_o, 0);
    checkOutput("busy_after_accept", busy_o, 1);

    cyc = 1;
    finished = 1'b0;
    while (!finished && cyc < budget) begin
      if (q_x.size() > 0) begin
        checkOutput("early_done", done_o, 0);
        checkOutput("we", we_o, 1);
        checkOutput("addr_x", addr_x_o, q_x[0]);
        checkOutput("addr_y", addr_y_o, q_y[0]);
        checkOutput("color", color_o, color);
        checkOutput("ready_in_fill", cmd_ready_o, 0);
        case (mode)
          1:       r = 1'($urandom_range(0, 1));
          2:       r = !(cyc >= 2 && cyc <= 4);
          default: r = 1'b1;
        endcase
        wr_ready_i = r;
        if (r) begin
          void'(q_x.pop_front());
          void'(q_y.pop_front());
        end
        if (mode == 3) begin
          cmd_x0_i    = 11'($urandom_range(0, 2047));
          cmd_y0_i    = 11'($urandom_range(0, 2047));
          cmd_x1_i    = 11'($urandom_range(0, 2047));
          cmd_y1_i    = 11'($urandom_range(0, 2047));
          cmd_color_i = 2'($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        cyc++;
      end else begin
        checkOutput("done", done_o, 1);
        checkOutput("empty", empty_o, (total == 0) ? 1 : 0);
        checkOutput("we_at_done", we_o, 0);
        checkOutput("busy_at_done", busy_o, 1);
        checkOutput("ready_at_done", cmd_ready_o, 0);
        finished = 1'b1;
      end
    end
    if (!finished) checkOutput("timeout", 0, 1);

    wr_ready_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("done_clear", done_o, 0);
    checkOutput("empty_clear", empty_o, 0);
    checkOutput("ready_after_done", cmd_ready_o, 1);
    checkOutput("busy_after_done", busy_o, 0);
  endtask

  initial begin
    int x0, y0, x1, y1, kind;
    arstn       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_x0_i    = '0;
    cmd_y0_i    = '0;
    cmd_x1_i    = '0;
    cmd_y1_i    = '0;
    cmd_color_i = '0;
    wr_ready_i  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", cmd_ready_o, 1);
    checkOutput("rst_we", we_o, 0);
    checkOutput("rst_addr_x", addr_x_o, 0);
    checkOutput("rst_addr_y", addr_y_o, 0);
    checkOutput("rst_color", color_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_empty", empty_o, 0);
    arstn = 1'b1;
    @(posedge clk); #1;

    applyStimulus(2, 3, 4, 4, 2, 0);
    applyStimulus(1278, 1022, 2000, 2000, 1, 0);
    applyStimulus(5, 0, 4, 0, 3, 0);
    applyStimulus(1280, 0, 1290, 0, 3, 0);
    applyStimulus(0, 0, 1, 0, 1, 2);
    applyStimulus(10, 10, 12, 11, 3, 3);
    applyStimulus(20, 20, 20, 20, 0, 0);
    applyStimulus(0, 1030, 3, 1040, 2, 0);

    // Reset while the third pixel of a 10x1 fill is on the bus.
    cmd_x0_i    = 11'd0;
    cmd_y0_i    = 11'd5;
    cmd_x1_i    = 11'd9;
    cmd_y1_i    = 11'd5;
    cmd_color_i = 2'd1;
    cmd_valid_i = 1'b1;
    wr_ready_i  = 1'b1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mid_third_x", addr_x_o, 2);
    checkOutput("mid_third_we", we_o, 1);
    arstn = 1'b0;
    @(posedge clk); #1;
    arstn = 1'b1;
    checkOutput("mid_rst_we", we_o, 0);
    checkOutput("mid_rst_busy", busy_o, 0);
    checkOutput("mid_rst_ready", cmd_ready_o, 1);
    checkOutput("mid_rst_done", done_o, 0);
    checkOutput("mid_rst_addr_x", addr_x_o, 0);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("mid_rst_no_done", done_o, 0);
      checkOutput("mid_rst_no_we", we_o, 0);
    end
    applyStimulus(7, 8, 9, 8, 2, 0);

    for (int i = 0; i < 30; i++) begin
      x0 = ($urandom_range(0, 3) == 0) ? $urandom_range(1270, 1285) : $urandom_range(0, 1270);
      y0 = ($urandom_range(0, 3) == 0) ? $urandom_range(1015, 1030) : $urandom_range(0, 1015);
      kind = $urandom_range(0, 7);
      if (kind == 0 && x0 > 0)
        x1 = x0 - 1;
      else if (kind == 1 && x0 >= 1270)
        x1 = 2047;
      else
        x1 = x0 + $urandom_range(0, 5);
      kind = $urandom_range(0, 7);
      if (kind == 0 && y0 > 0)
        y1 = y0 - 1;
      else if (kind == 1 && y0 >= 1015)
        y1 = 2047;
      else
        y1 = y0 + $urandom_range(0, 5);
      applyStimulus(x0, y0, x1, y1, $urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
